button_conditioner: RTL and testbench

//   Upstream input stage of the stopwatch. Synchronises, debounces and edge-detects the

---
 rtl/stopwatch_pkg.sv | 36 +++
 rtl/button_conditioner_if.sv | 35 +++
 rtl/debounce_channel.sv | 66 ++++++
 rtl/button_conditioner.sv | 58 +++++
 tb/tb_button_conditioner.sv | 150 +++++++++++++++
 5 files changed

// File: rtl/stopwatch_pkg.sv
// -----------------------------------------------------------------------------
// stopwatch_pkg
//   Constants and types shared by the button conditioner and the stopwatch core.
//   - BTN_* : which button channel carries which command
//   - DEBOUNCE_CYCLES_DEFAULT : 10 ms hold time at 24 MHz
//   - cmd_t / resolve_cmd : priority resolution of simultaneous presses
// -----------------------------------------------------------------------------
package stopwatch_pkg;

  localparam int N_BTN_DEFAULT           = 4;
  localparam int BTN_CLEAR               = 0;
  localparam int BTN_STOP                = 1;
  localparam int BTN_LAP                 = 2;
  localparam int BTN_START               = 3;
  localparam int DEBOUNCE_CYCLES_DEFAULT = 240000;
  localparam int CNT_W_DEFAULT           = 18;

  typedef struct packed {
    logic clear;
    logic stop;
    logic lap;
    logic start;
  } cmd_t;

  // Clear beats everything, stop beats start, lap rides along with stop or
  // start but is cancelled by clear.
  function automatic cmd_t resolve_cmd(input logic [3:0] p);
    cmd_t c;
    c.clear = p[BTN_CLEAR];
    c.stop  = p[BTN_STOP]  & ~p[BTN_CLEAR];
    c.lap   = p[BTN_LAP]   & ~p[BTN_CLEAR];
    c.start = p[BTN_START] & ~p[BTN_STOP] & ~p[BTN_CLEAR];
    return c;
  endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// -----------------------------------------------------------------------------
// button_conditioner_if
//   Bundles the raw button pins and the conditioned outputs.
//   master : pin side (drives btn_raw, observes the conditioned outputs)
//   slave  : the conditioner (reads btn_raw, drives everything else)
//   There is no valid/ready handshake: btn_raw is a free-running level, and
//   every other signal is a registered level or a single-cycle pulse that the
//   consumer must sample on the cycle it is high.
// -----------------------------------------------------------------------------
interface button_conditioner_if
  import stopwatch_pkg::*;
#(
  parameter int N_BTN = N_BTN_DEFAULT
);
  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;
  logic             cmd_clear;
  logic             cmd_stop;
  logic             cmd_lap;
  logic             cmd_start;

  modport master (
    output btn_raw,
    input  btn_level, btn_press, btn_release,
    input  cmd_clear, cmd_stop, cmd_lap, cmd_start
  );

  modport slave (
    input  btn_raw,
    output btn_level, btn_press, btn_release,
    output cmd_clear, cmd_stop, cmd_lap, cmd_start
  );
endinterface

// File: rtl/debounce_channel.sv
// -----------------------------------------------------------------------------
// debounce_channel
//   One button: 2-flop synchroniser, restart-on-bounce debounce counter,
//   debounced level and registered press/release pulses.
//   Ports:
//     i_clk, i_rst_n : clock, asynchronous active-low reset
//     i_raw          : raw pin, asynchronous to i_clk
//     o_level        : debounced level
//     o_press        : 1-cycle pulse on debounced 0->1
//     o_release      : 1-cycle pulse on debounced 1->0
// -----------------------------------------------------------------------------
module debounce_channel
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_W           = CNT_W_DEFAULT
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_raw,
  output logic o_level,
  output logic o_press,
  output logic o_release
);

  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_s1;
  logic             r_s2;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             r_press;
  logic             r_release;
  logic             w_next_level;

  // The level only moves once the synchronised input has disagreed with it
  // for DEBOUNCE_CYCLES consecutive cycles.
  assign w_next_level = ((r_s2 != r_level) && (r_cnt == LP_LAST)) ? r_s2 : r_level;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1      <= 1'b0;
      r_s2      <= 1'b0;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_s1 <= i_raw;
      r_s2 <= r_s1;
      // Any agreement (including a bounce back) restarts the count; the
      // accept cycle also returns it to 0, so it never wraps.
      if (r_s2 == r_level)      r_cnt <= '0;
      else if (r_cnt == LP_LAST) r_cnt <= '0;
      else                      r_cnt <= r_cnt + 1'b1;
      r_level   <= w_next_level;
      r_press   <= w_next_level & ~r_level;
      r_release <= ~w_next_level & r_level;
    end
  end

  assign o_level   = r_level;
  assign o_press   = r_press;
  assign o_release = r_release;

endmodule

// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//   Input stage of the stopwatch: synchronises, debounces and edge-detects the
//   raw buttons, then turns presses into priority-resolved command pulses.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     bus        : button_conditioner_if.slave
//                  btn_raw in; btn_level/btn_press/btn_release and
//                  cmd_clear/cmd_stop/cmd_lap/cmd_start out
//   Commands appear one cycle after the btn_press pulse that caused them.
// -----------------------------------------------------------------------------
module button_conditioner
  import stopwatch_pkg::*;
#(
  parameter int N_BTN           = N_BTN_DEFAULT,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_W           = CNT_W_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  button_conditioner_if.slave bus
);

  logic [N_BTN-1:0] w_level;
  logic [N_BTN-1:0] w_press;
  logic [N_BTN-1:0] w_release;
  cmd_t             r_cmd;

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_ch (
      .i_clk     (clk),
      .i_rst_n   (rst_n),
      .i_raw     (bus.btn_raw[g]),
      .o_level   (w_level[g]),
      .o_press   (w_press[g]),
      .o_release (w_release[g])
    );
  end

  // Commands derive from press pulses only, so a held button yields a single
  // command and a release yields none.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_cmd <= '0;
    else        r_cmd <= resolve_cmd(w_press[BTN_START:BTN_CLEAR]);
  end

  assign bus.btn_level   = w_level;
  assign bus.btn_press   = w_press;
  assign bus.btn_release = w_release;
  assign bus.cmd_clear   = r_cmd.clear;
  assign bus.cmd_stop    = r_cmd.stop;
  assign bus.cmd_lap     = r_cmd.lap;
  assign bus.cmd_start   = r_cmd.start;

endmodule

// File: tb/tb_button_conditioner.sv
// -----------------------------------------------------------------------------
// tb_button_conditioner
//   Directed bench for button_conditioner with DEBOUNCE_CYCLES=8.
//   Observed word per cycle: {level[3:0], press[3:0], release[3:0], cmd[3:0]}
//   with cmd = {clear, stop, lap, start}. Raw pins change 1 time unit after a
//   rising edge; call that following edge E0. The debounced level and press
//   then appear at E9 and the command at E10.
// -----------------------------------------------------------------------------
module tb_button_conditioner;

  logic clk;
  logic rst_n;

  button_conditioner_if #(.N_BTN(4)) bus ();

  button_conditioner #(
    .N_BTN           (4),
    .DEBOUNCE_CYCLES (8),
    .CNT_W           (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [15:0] exp_q[$];

  typedef struct {
    logic [3:0] on;   // raw pins raised
    logic [3:0] cmd;  // expected {clear, stop, lap, start}
  } vec_t;

  vec_t vecs[8];

  function automatic logic [15:0] observe();
    return {bus.btn_level, bus.btn_press, bus.btn_release,
            bus.cmd_clear, bus.cmd_stop, bus.cmd_lap, bus.cmd_start};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raw pins already set to 'on' just after an edge; level/press arrive at
  // E9, the command at E10.
  task automatic press_phase(input logic [3:0] on, input logic [3:0] cmd, input string tag);
    for (int i = 0; i <= 12; i++)
      exp_q.push_back({(i >= 9) ? on : 4'h0, (i == 9) ? on : 4'h0, 4'h0,
                       (i == 10) ? cmd : 4'h0});
    for (int i = 0; i <= 12; i++) begin
      tick();
      check($sformatf("%s_press_c%0d", tag, i), observe(), exp_q.pop_front());
    end
  endtask

  // Drop all pins; the release pulse arrives at E9 and no command follows.
  task automatic release_phase(input logic [3:0] on, input string tag);
    bus.btn_raw = 4'h0;
    for (int i = 0; i <= 12; i++)
      exp_q.push_back({(i < 9) ? on : 4'h0, 4'h0, (i == 9) ? on : 4'h0, 4'h0});
    for (int i = 0; i <= 12; i++) begin
      tick();
      check($sformatf("%s_release_c%0d", tag, i), observe(), exp_q.pop_front());
    end
  endtask

  initial begin
    logic bounce[12];
    logic [15:0] e;

    // hand-computed command table
    vecs[0] = '{on: 4'b1000, cmd: 4'b0001}; // start
    vecs[1] = '{on: 4'b1010, cmd: 4'b0100}; // stop beats start
    vecs[2] = '{on: 4'b0100, cmd: 4'b0010}; // lap
    vecs[3] = '{on: 4'b1100, cmd: 4'b0011}; // lap + start
    vecs[4] = '{on: 4'b0110, cmd: 4'b0110}; // stop + lap
    vecs[5] = '{on: 4'b0001, cmd: 4'b1000}; // clear
    vecs[6] = '{on: 4'b0111, cmd: 4'b1000}; // clear cancels stop and lap
    vecs[7] = '{on: 4'b1111, cmd: 4'b1000}; // clear beats everything
    bounce = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    // 1. reset with all pins high
    rst_n       = 1'b0;
    bus.btn_raw = 4'hF;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("reset_c%0d", i), observe(), 16'h0000);
    end
    rst_n = 1'b1;
    press_phase(4'hF, 4'b1000, "from_reset");
    release_phase(4'hF, "from_reset");

    // 2/4/5. single and simultaneous presses, each followed by a release
    for (int k = 0; k < 8; k++) begin
      bus.btn_raw = vecs[k].on;
      press_phase(vecs[k].on, vecs[k].cmd, $sformatf("vec%0d", k));
      release_phase(vecs[k].on, $sformatf("vec%0d", k));
    end

    // 3. bounce on button 2: the 0 at step 3 restarts the count, so the press
    //    lands at E13 instead of E9 and the lap command at E14
    for (int i = 0; i <= 20; i++) begin
      bus.btn_raw = {1'b0, (i < 12) ? bounce[i] : 1'b1, 2'b00};
      e = {(i >= 13) ? 4'b0100 : 4'h0, (i == 13) ? 4'b0100 : 4'h0, 4'h0,
           (i == 14) ? 4'b0010 : 4'h0};
      tick();
      check($sformatf("bounce_c%0d", i), observe(), e);
    end
    release_phase(4'b0100, "bounce");

    // 6. reset in the middle of a debounce
    bus.btn_raw = 4'b0010;
    press_phase(4'b0010, 4'b0100, "pre_reset");
    bus.btn_raw = 4'b1010;
    for (int i = 0; i <= 6; i++) begin
      tick();
      check($sformatf("mid_debounce_c%0d", i), observe(), {4'b0010, 12'h000});
    end
    // button 3 counter now at 5; reset lands between edges
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", observe(), 16'h0000);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("in_reset_c%0d", i), observe(), 16'h0000);
    end
    rst_n = 1'b1;
    press_phase(4'b1010, 4'b0100, "post_reset");
    release_phase(4'b1010, "post_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
